reg_write_sequencer: RTL

//  Writer side of the 32x32 register bank write port (AW/DATAIN/REG_WRITE).

---
 rtl/reg_write_sequencer_pkg.sv | 18 +
 rtl/reg_write_sequencer_if.sv | 44 ++++
 rtl/reg_write_sequencer_wb_fifo.sv | 79 +++++++
 rtl/reg_write_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/reg_write_sequencer_pkg.sv
// Shared register-bank definitions for the writeback sequencer.
// Contents: address/data widths, the hard-wired zero register,
// the default queue depth and the queued {addr,data} payload type.
package reg_write_sequencer_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH_DEF = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // One pending register write
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_write_sequencer_if.sv
// Writeback bus between the two producers / decode stage and the sequencer.
// master: producers + decode (drive requests, flush, read addresses)
// slave : sequencer (drives ready, bank write port, forwarding, status)
interface reg_write_sequencer_if
    import reg_write_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic [ADDR_W-1:0] aw;
    logic [DATA_W-1:0] datain;
    logic              reg_write;
    logic [ADDR_W-1:0] ar1;
    logic [ADDR_W-1:0] ar2;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd2_data;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output flush, b_valid, b_addr, b_data, a_valid, a_addr, a_data, ar1, ar2,
        input  b_ready, a_ready, aw, datain, reg_write,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count, empty
    );

    modport slave (
        input  flush, b_valid, b_addr, b_data, a_valid, a_addr, a_data, ar1, ar2,
        output b_ready, a_ready, aw, datain, reg_write,
               fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, count, empty
    );

endinterface

// File: rtl/reg_write_sequencer_wb_fifo.sv
// DEPTH-entry circular buffer of pending register writes.
// Ports: clk, rst_n; flush_i clears all entries; push0_i/push0_entry_i is the
// older of two same-cycle pushes, push1_i/push1_entry_i the younger; pop_i
// removes the head (head_o). count_o is the registered occupancy,
// count_nxt_c its next value. entries_o/valid_o list the stored entries in
// age order (index 0 = oldest) for forwarding.
module reg_write_sequencer_wb_fifo
    import reg_write_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push0_i,
    input  wb_entry_t                push0_entry_i,
    input  logic                     push1_i,
    input  wb_entry_t                push1_entry_i,
    input  logic                     pop_i,
    output wb_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [$clog2(DEPTH):0]   count_nxt_c,
    output wb_entry_t                entries_o [DEPTH],
    output logic [DEPTH-1:0]         valid_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Pointer/occupancy next state; flush overrides everything
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage: the younger push lands one slot after the older one
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (push0_i) mem_q[wr_ptr_q] <= push0_entry_i;
            if (push1_i) mem_q[push0_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q] <= push1_entry_i;
        end
    end

    // Age-ordered view of the queue
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_o[i] = mem_q[rd_ptr_q + PTR_W'(i)];
            valid_o[i]   = (CNT_W'(i) < count_q);
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign count_nxt_c = count_d;

endmodule

// File: rtl/reg_write_sequencer.sv
// Writer side of the 32x32 register bank write port.
// Accepts writes from the load path (B, older) and ALU path (A, younger),
// queues them in program order, issues at most one registered bank write
// per clock and forwards pending values to the two decode read ports.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carrying the
// request handshakes, flush, bank write port (aw/datain/reg_write),
// read addresses with forwarding results, and count/empty status.
module reg_write_sequencer
    import reg_write_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_write_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic [CNT_W-1:0]  free;
    logic              pop;
    logic              b_ready;
    logic              a_ready;
    logic              push_b;
    logic              push_a;
    wb_entry_t         head;
    wb_entry_t         entries [DEPTH];
    logic [DEPTH-1:0]  valid;

    logic [ADDR_W-1:0] aw_q, aw_d;
    logic [DATA_W-1:0] datain_q, datain_d;
    logic              reg_write_q, reg_write_d;
    logic              empty_q, empty_d;

    logic              fwd1_hit, fwd2_hit;
    logic [DATA_W-1:0] fwd1_data, fwd2_data;

    // Head drains every cycle the queue holds anything, unless flushed
    assign pop  = (count != '0) && !bus.flush;
    assign free = CNT_W'(DEPTH) - count + CNT_W'(pop);

    // A needs room behind a concurrent B request, since B is older
    always_comb begin
        b_ready = 1'b0;
        a_ready = 1'b0;
        if (!bus.flush) begin
            b_ready = (free >= CNT_W'(1));
            a_ready = bus.b_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1));
        end
    end

    // Writes to the zero register are handshaken but never stored
    assign push_b = bus.b_valid && b_ready && (bus.b_addr != REG_ZERO);
    assign push_a = bus.a_valid && a_ready && (bus.a_addr != REG_ZERO);

    reg_write_sequencer_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (bus.flush),
        .push0_i       (push_b),
        .push0_entry_i ({bus.b_addr, bus.b_data}),
        .push1_i       (push_a),
        .push1_entry_i ({bus.a_addr, bus.a_data}),
        .pop_i         (pop),
        .head_o        (head),
        .count_o       (count),
        .count_nxt_c   (count_nxt),
        .entries_o     (entries),
        .valid_o       (valid)
    );

    // Output stage: one-cycle write pulse per popped entry, address/data hold otherwise
    always_comb begin
        aw_d        = aw_q;
        datain_d    = datain_q;
        reg_write_d = 1'b0;
        if (pop) begin
            aw_d        = head.addr;
            datain_d    = head.data;
            reg_write_d = 1'b1;
        end
        empty_d = (count_nxt == '0) && !reg_write_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_q        <= '0;
            datain_q    <= '0;
            reg_write_q <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            aw_q        <= aw_d;
            datain_q    <= datain_d;
            reg_write_q <= reg_write_d;
            empty_q     <= empty_d;
        end
    end

    // Forwarding: scan oldest (output stage) to youngest so the last match wins
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        if (reg_write_q && (aw_q == bus.ar1)) begin
            fwd1_hit  = 1'b1;
            fwd1_data = datain_q;
        end
        if (reg_write_q && (aw_q == bus.ar2)) begin
            fwd2_hit  = 1'b1;
            fwd2_data = datain_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entries[i].addr == bus.ar1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = entries[i].data;
            end
            if (valid[i] && (entries[i].addr == bus.ar2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = entries[i].data;
            end
        end
        if (bus.ar1 == REG_ZERO) begin
            fwd1_hit  = 1'b0;
            fwd1_data = '0;
        end
        if (bus.ar2 == REG_ZERO) begin
            fwd2_hit  = 1'b0;
            fwd2_data = '0;
        end
    end

    assign bus.b_ready   = b_ready;
    assign bus.a_ready   = a_ready;
    assign bus.aw        = aw_q;
    assign bus.datain    = datain_q;
    assign bus.reg_write = reg_write_q;
    assign bus.fwd1_hit  = fwd1_hit;
    assign bus.fwd1_data = fwd1_data;
    assign bus.fwd2_hit  = fwd2_hit;
    assign bus.fwd2_data = fwd2_data;
    assign bus.count     = count;
    assign bus.empty     = empty_q;

endmodule
